mig_burst_ctrl: RTL and testbench
=================================

// Module: mig_burst_ctrl
// PURPOSE
//  Responder side of the user burst interface: accepts wr/rd burst requests (addr, length in 128-bit beats)
//  from a traffic source and converts them to MIG 7-series native app_* commands, one app word per beat.
//  Sits between user logic and the MIG core in the ui_clk domain; one burst in flight at a time.
// PARAMETERS
//  ADDR_W    28   width of request address and app_addr
//  DATA_W    128  app data width (one beat)
//  ADDR_INC  8    app_addr increment per beat (BL8, 4:1 mode)
// PORTS
//  ui_clk              in   1       MIG user clock; only clock
//  ui_rst              in   1       synchronous, active-high reset
//  init_calib_complete in   1       MIG calibration done; no request accepted while low
//  wr_req              in   1       write burst request (level; sampled only when accept allowed)
//  wr_req_addr         in   ADDR_W  write start address
//  wr_length           in   16      write beats
//  wr_data             in   DATA_W  current write beat; must advance the cycle after wr_data_valid
//  wr_busy             out  1       write channel busy
//  wr_data_valid       out  1       strobe: wr_data consumed this cycle
//  wr_done             out  1       1-cycle pulse: write burst complete
//  rd_req              in   1       read burst request
//  rd_req_addr         in   ADDR_W  read start address
//  rd_length           in   16      read beats
//  rd_data             out  DATA_W  read beat (= app_rd_data)
//  rd_busy             out  1       read channel busy
//  rd_data_valid       out  1       strobe: rd_data valid
//  rd_done             out  1       1-cycle pulse: read burst complete
//  app_addr            out  ADDR_W  MIG command address
//  app_cmd             out  3       000 write, 001 read
//  app_en              out  1       MIG command enable
//  app_rdy             in   1       MIG command ready
//  app_wdf_data        out  DATA_W  MIG write data (= wr_data)
//  app_wdf_wren        out  1       MIG write data enable
//  app_wdf_end         out  1       = app_wdf_wren (one word per burst)
//  app_wdf_mask        out  DATA_W/8 tied 0
//  app_wdf_rdy         in   1       MIG write FIFO ready
//  app_rd_data         in   DATA_W  MIG read data
//  app_rd_data_valid   in   1       MIG read data valid
// BEHAVIOUR
//  FSM IDLE, WR, RD, DONE. Reset (ui_rst=1 at edge): state IDLE, counters 0, all outputs 0, last_wr=0.
//  wr_busy = rd_busy = (state != IDLE). Requests ignored while busy or init_calib_complete=0.
//  IDLE: accept when calibrated; latch addr/length/direction. Both requests -> serve the one not served
//   last (after reset write wins). Accept cycle N: busy=1 from N+1.
//  length 0: accepted, no app_* activity, goes straight to DONE -> done pulse at N+2.
//  WR: beat_ok = app_rdy & app_wdf_rdy & (wcnt < len). app_en = (wcnt<len) & app_wdf_rdy;
//   app_wdf_wren = (wcnt<len) & app_rdy, so cmd and data are accepted in the same cycle only.
//   wr_data_valid = beat_ok (combinational); app_addr = base + wcnt*ADDR_INC (mod 2^ADDR_W, wraps).
//   Last beat accepted -> DONE next cycle.
//  RD: app_en = (ccnt < len); cmd accepted on app_en & app_rdy, ccnt++. rd_data_valid = app_rd_data_valid
//   while in RD; rcnt counts returned beats; last beat returned -> DONE next cycle. Read data arriving
//   in any other state is dropped (no rd_data_valid).
//  DONE: one cycle; wr_done or rd_done = 1 per latched direction, busy still 1; then IDLE.
//  Back-to-back: new request accepted earliest in the IDLE cycle after DONE.
//  Reset mid-burst: abort immediately, no done pulse, outputs 0 next cycle.
// TESTING
//  wr_req, addr 0, len 256, rdys held 1 -> 256 wr_data_valid in 256 cycles, app_addr 0..2040 step 8, one wr_done.
//  Same with app_rdy toggling 1/0 and app_wdf_rdy 2-cycle low gaps -> wren/en accepted only together, 256 beats, data in order.
//  rd len 4, addr 0x0FFFFFF8 -> app_addr 0x0FFFFFF8,0,8,16 (wrap); 4 rd_data_valid, rd_done after 4th.
//  wr_req and rd_req high together from reset -> write served first, then read, alternating thereafter.
//  ui_rst at beat 100 of 256 write -> no wr_done, all outputs 0; init_calib_complete=0 -> requests ignored.

Source files
------------

// File: rtl/mig_burst_ctrl_if.sv
// User burst channel and MIG native app_* channel bundles.
// mig_user_if: master = traffic source, slave = burst controller.
// mig_app_if:  master = burst controller, slave = MIG core.
interface mig_user_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [15:0]       wr_length;
    logic [DATA_W-1:0] wr_data;
    logic              wr_busy;
    logic              wr_data_valid;
    logic              wr_done;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_req_addr;
    logic [15:0]       rd_length;
    logic [DATA_W-1:0] rd_data;
    logic              rd_busy;
    logic              rd_data_valid;
    logic              rd_done;

    modport master (
        output wr_req, wr_req_addr, wr_length, wr_data, rd_req, rd_req_addr, rd_length,
        input  wr_busy, wr_data_valid, wr_done, rd_data, rd_busy, rd_data_valid, rd_done
    );
    modport slave (
        input  wr_req, wr_req_addr, wr_length, wr_data, rd_req, rd_req_addr, rd_length,
        output wr_busy, wr_data_valid, wr_done, rd_data, rd_busy, rd_data_valid, rd_done
    );
endinterface

interface mig_app_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic [ADDR_W-1:0]   app_addr;
    logic [2:0]          app_cmd;
    logic                app_en;
    logic                app_rdy;
    logic [DATA_W-1:0]   app_wdf_data;
    logic                app_wdf_wren;
    logic                app_wdf_end;
    logic [DATA_W/8-1:0] app_wdf_mask;
    logic                app_wdf_rdy;
    logic [DATA_W-1:0]   app_rd_data;
    logic                app_rd_data_valid;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/mig_burst_ctrl.sv
// Burst-to-MIG native command converter: one user burst in flight, one app word per 128-bit beat.
// state | meaning: IDLE accept request | WR issue write beats | RD issue reads, collect data | DONE done pulse
module mig_burst_ctrl #(
    parameter int ADDR_W   = 28,
    parameter int DATA_W   = 128,
    parameter int ADDR_INC = 8
) (
    input  logic      ui_clk_i,
    input  logic      ui_rst_i,
    input  logic      init_calib_complete_i,
    mig_user_if.slave usr,
    mig_app_if.master app
);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DONE} state_e;

    state_e            state_q, state_d;
    logic              rd_dir_q, rd_dir_d;
    logic              last_wr_q, last_wr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       len_q, len_d;
    logic [16:0]       cnt_q, cnt_d;
    logic [16:0]       rcnt_q, rcnt_d;

    logic pend;
    logic take_wr;
    logic beat_ok;
    logic cmd_ok;
    logic cnt_last;
    logic rcnt_last;

    assign pend      = cnt_q < {1'b0, len_q};
    assign take_wr   = usr.wr_req & (~usr.rd_req | ~last_wr_q);
    assign beat_ok   = (state_q == S_WR) & pend & app.app_rdy & app.app_wdf_rdy;
    assign cmd_ok    = (state_q == S_RD) & pend & app.app_rdy;
    assign cnt_last  = (cnt_q + 17'd1) == {1'b0, len_q};
    assign rcnt_last = (rcnt_q + 17'd1) == {1'b0, len_q};

    always_ff @(posedge ui_clk_i) begin
        if (ui_rst_i) begin
            state_q   <= S_IDLE;
            rd_dir_q  <= 1'b0;
            last_wr_q <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            rcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            rd_dir_q  <= rd_dir_d;
            last_wr_q <= last_wr_d;
            base_q    <= base_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_dir_d  = rd_dir_q;
        last_wr_d = last_wr_q;
        base_d    = base_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (init_calib_complete_i && (usr.wr_req || usr.rd_req)) begin
                    last_wr_d = take_wr;
                    rd_dir_d  = ~take_wr;
                    base_d    = take_wr ? usr.wr_req_addr : usr.rd_req_addr;
                    len_d     = take_wr ? usr.wr_length : usr.rd_length;
                    cnt_d     = '0;
                    rcnt_d    = '0;
                    state_d   = take_wr ? S_WR : S_RD;
                end
            end
            S_WR: begin
                if (beat_ok) cnt_d = cnt_q + 17'd1;
                // a zero-length burst passes through here for one idle cycle
                if (!pend || (beat_ok && cnt_last)) state_d = S_DONE;
            end
            S_RD: begin
                if (cmd_ok) cnt_d = cnt_q + 17'd1;
                if (app.app_rd_data_valid) rcnt_d = rcnt_q + 17'd1;
                if ((rcnt_q >= {1'b0, len_q}) || (app.app_rd_data_valid && rcnt_last)) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        app.app_addr      = base_q + ADDR_W'(cnt_q) * ADDR_W'(ADDR_INC);
        app.app_cmd       = rd_dir_q ? 3'b001 : 3'b000;
        app.app_en        = 1'b0;
        app.app_wdf_wren  = 1'b0;
        usr.wr_data_valid = 1'b0;
        usr.rd_data_valid = 1'b0;
        usr.wr_done       = 1'b0;
        usr.rd_done       = 1'b0;
        usr.wr_busy       = (state_q != S_IDLE);
        usr.rd_busy       = (state_q != S_IDLE);
        unique case (state_q)
            S_WR: begin
                // cmd and data are each gated by the other side's ready so both land together
                app.app_en        = pend & app.app_wdf_rdy;
                app.app_wdf_wren  = pend & app.app_rdy;
                usr.wr_data_valid = beat_ok;
            end
            S_RD: begin
                app.app_en        = pend;
                usr.rd_data_valid = app.app_rd_data_valid;
            end
            S_DONE: begin
                usr.wr_done = ~rd_dir_q;
                usr.rd_done = rd_dir_q;
            end
            default: ;
        endcase
    end

    assign app.app_wdf_end  = app.app_wdf_wren;
    assign app.app_wdf_data = usr.wr_data;
    assign app.app_wdf_mask = '0;
    assign usr.rd_data      = app.app_rd_data;

endmodule

// File: tb/tb_mig_burst_ctrl.sv
// Scoreboard bench for mig_burst_ctrl: directed bursts, a small MIG model and a negedge monitor.
module tb_mig_burst_ctrl;
    localparam int AW = 28;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst;
    logic calib;
    always #5 clk = ~clk;

    mig_user_if #(.ADDR_W(AW), .DATA_W(DW)) usr ();
    mig_app_if  #(.ADDR_W(AW), .DATA_W(DW)) app ();

    mig_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ADDR_INC(8)) dut (
        .ui_clk_i              (clk),
        .ui_rst_i              (rst),
        .init_calib_complete_i (calib),
        .usr                   (usr.slave),
        .app                   (app.master)
    );

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wbeat_t;
    typedef struct { logic [AW-1:0] addr; int due; } rq_t;

    wbeat_t          exp_w[$];
    logic [AW-1:0]   exp_ra[$];
    logic [DW-1:0]   exp_rd[$];
    bit              exp_done[$];
    rq_t             rq[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int unsigned wtotal = 0;
    bit          wv_seen = 0;
    bit          inject = 0;
    int          rdy_mode = 0;

    function automatic logic [DW-1:0] wfun(input int unsigned n);
        return {n, ~n, n + 32'h1000, n ^ 32'hDEAD0000};
    endfunction

    function automatic logic [DW-1:0] rfun(input logic [AW-1:0] a);
        logic [31:0] x;
        x = {4'h0, a};
        return {x, ~x, 32'h12345678, x + 32'd1};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flags"}, {usr.wr_busy, usr.rd_busy, usr.wr_data_valid, usr.wr_done,
              usr.rd_data_valid, usr.rd_done, app.app_en, app.app_wdf_wren, app.app_wdf_end}, 0);
        check({tag, "_addr"}, app.app_addr, 0);
        check({tag, "_cmd"}, app.app_cmd, 0);
        check({tag, "_mask"}, app.app_wdf_mask, 0);
    endtask

    // MIG model and write-data source; runs after the main stimulus settles
    always @(posedge clk) begin
        #2;
        cyc++;
        if (wv_seen) wtotal++;
        usr.wr_data = wfun(wtotal);
        if (rdy_mode == 0) begin
            app.app_rdy     = 1'b1;
            app.app_wdf_rdy = 1'b1;
        end else begin
            app.app_rdy     = cyc[0];
            app.app_wdf_rdy = (cyc % 5) >= 2;
        end
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            app.app_rd_data_valid = 1'b1;
            app.app_rd_data       = rfun(rq[0].addr);
            void'(rq.pop_front());
        end else if (inject) begin
            app.app_rd_data_valid = 1'b1;
            app.app_rd_data       = '1;
        end else begin
            app.app_rd_data_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic cmd_w, dat_w;
        wbeat_t e;
        wv_seen = usr.wr_data_valid;
        cmd_w = app.app_en & app.app_rdy & (app.app_cmd == 3'b000);
        dat_w = app.app_wdf_wren & app.app_wdf_rdy;
        if (cmd_w | dat_w | usr.wr_data_valid) begin
            check("wr_cmd_vs_data", cmd_w, dat_w);
            check("wr_valid_vs_data", usr.wr_data_valid, dat_w);
            check("wdf_end", app.app_wdf_end, app.app_wdf_wren);
        end
        if (usr.wr_data_valid) begin
            if (exp_w.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL wr_beat: unexpected beat addr %h", app.app_addr);
            end else begin
                e = exp_w.pop_front();
                check("wr_addr", app.app_addr, e.addr);
                check("wr_data", app.app_wdf_data, e.data);
            end
        end
        if (app.app_en & app.app_rdy & (app.app_cmd == 3'b001)) begin
            if (exp_ra.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rd_cmd: unexpected command addr %h", app.app_addr);
            end else begin
                check("rd_addr", app.app_addr, exp_ra.pop_front());
            end
            rq.push_back('{app.app_addr, cyc + 3});
        end
        if (usr.rd_data_valid) begin
            if (exp_rd.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rd_beat: unexpected rd_data_valid data %h", usr.rd_data);
            end else begin
                check("rd_data", usr.rd_data, exp_rd.pop_front());
            end
        end
        if (usr.wr_done | usr.rd_done) begin
            if (exp_done.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL done: unexpected wr_done=%0b rd_done=%0b", usr.wr_done, usr.rd_done);
            end else begin
                check("done_dir", {usr.wr_done, usr.rd_done}, exp_done.pop_front() ? 2'b10 : 2'b01);
                check("done_busy", usr.wr_busy & usr.rd_busy, 1);
            end
        end
    end

    task automatic push_wr(input logic [AW-1:0] base, input int len, input int unsigned start);
        wbeat_t e;
        for (int i = 0; i < len; i++) begin
            e.addr = base + AW'(i) * AW'(8);
            e.data = wfun(start + i);
            exp_w.push_back(e);
        end
    endtask

    task automatic push_rd(input logic [AW-1:0] base, input int len);
        logic [AW-1:0] a;
        for (int i = 0; i < len; i++) begin
            a = base + AW'(i) * AW'(8);
            exp_ra.push_back(a);
            exp_rd.push_back(rfun(a));
        end
    endtask

    task automatic issue(input bit w, input bit r);
        @(posedge clk); #1;
        usr.wr_req = w;
        usr.rd_req = r;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (usr.wr_busy) break;
        end
        if (!usr.wr_busy) begin
            n_cmp++; n_bad++;
            $display("FAIL accept: request not taken, busy %0b required 1", usr.wr_busy);
        end
        usr.wr_req = 1'b0;
        usr.rd_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int nb, output int first, output int last,
                             output int nd, output int dk);
        nb = 0; first = -1; last = -1; nd = 0; dk = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (usr.wr_data_valid | usr.rd_data_valid) begin
                nb++;
                if (first < 0) first = k;
                last = k;
            end
            if (usr.wr_done | usr.rd_done) begin
                nd++;
                dk = k;
            end
            if (!usr.wr_busy) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, fb, lb, nd, dk, cnt;
        int unsigned s;
        rst = 1'b1; calib = 1'b0;
        usr.wr_req = 1'b0; usr.rd_req = 1'b0;
        usr.wr_req_addr = '0; usr.rd_req_addr = '0;
        usr.wr_length = '0; usr.rd_length = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");

        // uncalibrated: both requests held, nothing may happen
        @(posedge clk); #1;
        rst = 1'b0;
        usr.wr_req = 1'b1; usr.rd_req = 1'b1;
        usr.wr_length = 16'd4; usr.rd_length = 16'd4;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (usr.wr_busy | usr.rd_busy | app.app_en | app.app_wdf_wren) cnt++;
        end
        check("calib_ignore", cnt, 0);
        @(posedge clk); #1;
        usr.wr_req = 1'b0; usr.rd_req = 1'b0;
        calib = 1'b1;

        // 256-beat write, readies held high: one beat per cycle
        rdy_mode = 0;
        usr.wr_req_addr = 28'h0; usr.wr_length = 16'd256;
        push_wr(28'h0, 256, wtotal);
        exp_done.push_back(1'b1);
        issue(1'b1, 1'b0);
        wait_idle(400, nb, fb, lb, nd, dk);
        check("w256_beats", nb, 256);
        check("w256_span", lb - fb + 1, 256);
        check("w256_done_cnt", nd, 1);
        check("w256_done_at", dk, lb + 1);

        // 256-beat write with app_rdy toggling and app_wdf_rdy gaps
        rdy_mode = 1;
        usr.wr_req_addr = 28'h100;
        push_wr(28'h100, 256, wtotal);
        exp_done.push_back(1'b1);
        issue(1'b1, 1'b0);
        wait_idle(3000, nb, fb, lb, nd, dk);
        check("w256g_beats", nb, 256);
        check("w256g_done_cnt", nd, 1);

        // 4-beat read across the address wrap
        rdy_mode = 0;
        usr.rd_req_addr = 28'h0FFFFF8; usr.rd_length = 16'd4;
        usr.rd_req_addr = 28'hFFFFFF8;
        exp_ra.push_back(28'hFFFFFF8); exp_ra.push_back(28'h0);
        exp_ra.push_back(28'h8);       exp_ra.push_back(28'h10);
        exp_rd.push_back(rfun(28'hFFFFFF8)); exp_rd.push_back(rfun(28'h0));
        exp_rd.push_back(rfun(28'h8));       exp_rd.push_back(rfun(28'h10));
        exp_done.push_back(1'b0);
        issue(1'b0, 1'b1);
        wait_idle(100, nb, fb, lb, nd, dk);
        check("rd4_beats", nb, 4);
        check("rd4_done_cnt", nd, 1);
        check("rd4_done_at", dk, lb + 1);

        // zero-length write: no app activity, done two cycles after accept
        usr.wr_length = 16'd0;
        exp_done.push_back(1'b1);
        @(posedge clk); #1;
        usr.wr_req = 1'b1;
        @(negedge clk);
        check("len0_busy_n", usr.wr_busy, 0);
        @(posedge clk); #1;
        usr.wr_req = 1'b0;
        @(negedge clk);
        check("len0_n1", {usr.wr_busy, usr.wr_done, app.app_en, app.app_wdf_wren}, 4'b1000);
        @(negedge clk);
        check("len0_n2", {usr.wr_busy, usr.wr_done, app.app_en, app.app_wdf_wren}, 4'b1100);
        @(negedge clk);
        check("len0_n3", usr.wr_busy, 0);

        // stray read data while idle is dropped
        @(posedge clk); #1;
        inject = 1'b1;
        @(negedge clk);
        check("drop_rdv", usr.rd_data_valid, 0);
        @(posedge clk); #1;
        inject = 1'b0;

        // both requests from reset: write, read, write, read, back to back
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        usr.wr_req_addr = 28'h200; usr.wr_length = 16'd3;
        usr.rd_req_addr = 28'h300; usr.rd_length = 16'd2;
        s = wtotal;
        push_wr(28'h200, 3, s);
        push_rd(28'h300, 2);
        push_wr(28'h200, 3, s + 3);
        push_rd(28'h300, 2);
        exp_done.push_back(1'b1); exp_done.push_back(1'b0);
        exp_done.push_back(1'b1); exp_done.push_back(1'b0);
        @(posedge clk); #1;
        usr.wr_req = 1'b1; usr.rd_req = 1'b1;
        for (int d = 0; d < 4; d++) begin
            cnt = 0;
            while (!(usr.wr_done | usr.rd_done) && cnt < 60) begin
                @(negedge clk);
                cnt++;
            end
            check("alt_done_seen", usr.wr_done | usr.rd_done, 1);
            if (d < 3) begin
                @(negedge clk);
                check("b2b_idle", usr.wr_busy, 0);
                @(negedge clk);
                check("b2b_accept", usr.wr_busy, 1);
            end
        end
        @(posedge clk); #1;
        usr.wr_req = 1'b0; usr.rd_req = 1'b0;
        repeat (3) @(negedge clk);
        check("alt_idle", usr.wr_busy, 0);

        // reset in the middle of a 256-beat write
        rdy_mode = 0;
        usr.wr_req_addr = 28'h400; usr.wr_length = 16'd256;
        s = wtotal;
        push_wr(28'h400, 256, s);
        issue(1'b1, 1'b0);
        cnt = 0;
        while ((wtotal - s) < 100 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("abort_reach100", (wtotal - s) >= 100, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("abort");
        check("abort_partial", exp_w.size() > 0, 1);
        exp_w.delete();
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (usr.wr_done | usr.rd_done | usr.wr_busy) cnt++;
        end
        check("abort_no_done", cnt, 0);

        check("left_wr", exp_w.size(), 0);
        check("left_ra", exp_ra.size(), 0);
        check("left_rd", exp_rd.size(), 0);
        check("left_done", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
